// File: rtl/bus_datapath_seq.sv
// Single-bus micro-sequenced datapath: register file, Y/Z latches and a small ALU.
// Each operation walks IDLE -> TA (load Y) -> TB (compute Z) -> TW (write back).
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int R0_ZERO  = 0
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic [$clog2(NUM_REGS)-1:0] rs,
  input  logic [$clog2(NUM_REGS)-1:0] rt,
  input  logic [$clog2(NUM_REGS)-1:0] rd,
  input  logic                        ext_we,
  input  logic [$clog2(NUM_REGS)-1:0] ext_addr,
  input  logic [DATA_W-1:0]           ext_wdata,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        zero,
  output logic [DATA_W-1:0]           hi,
  output logic [DATA_W-1:0]           lo
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int SW = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_PAS = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, TA = 2'd1, TB = 2'd2, TW = 2'd3} state_t;

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [DATA_W-1:0]   y_r, hi_r, lo_r, bus_s, wdata_s;
  logic [2*DATA_W-1:0] z_r;
  logic [2:0]          op_r;
  logic [AW-1:0]       rs_r, rt_r, rd_r, waddr_s;
  logic                done_r, zero_r, latch_s, wr_req_s, we_s;

  // Hardwired-zero R0 view applied to every register read.
  function automatic logic [DATA_W-1:0] mask_r0(input logic [AW-1:0] a, input logic [DATA_W-1:0] v);
    mask_r0 = ((R0_ZERO != 0) && (a == {AW{1'b0}})) ? {DATA_W{1'b0}} : v;
  endfunction

  // Zhigh stays zero for everything except the full-width product.
  function automatic logic [2*DATA_W-1:0] alu(input logic [2:0] f, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SHL:  r = a << b[SW-1:0];
      OP_SHR:  r = a >> b[SW-1:0];
      OP_PAS:  r = a;
      default: r = {DATA_W{1'b0}};
    endcase
    if (f == OP_MUL) alu = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    else             alu = {{DATA_W{1'b0}}, r};
  endfunction

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = TA;
          latch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      TA:      state_s = TB;
      TB:      state_s = TW;
      TW:      state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Internal bus source select.
  always_comb begin
    bus_s = {DATA_W{1'b0}};
    case (state_r)
      TA:      bus_s = mask_r0(rs_r, regs_r[rs_r]);
      TB:      bus_s = mask_r0(rt_r, regs_r[rt_r]);
      TW:      bus_s = z_r[DATA_W-1:0];
      default: bus_s = {DATA_W{1'b0}};
    endcase
  end

  // Single register-file write port shared by preload (IDLE only) and write-back.
  always_comb begin
    wr_req_s = 1'b0;
    waddr_s  = ext_addr;
    wdata_s  = ext_wdata;
    if ((state_r == IDLE) && ext_we) begin
      wr_req_s = 1'b1;
    end else if ((state_r == TW) && (op_r != OP_MUL)) begin
      wr_req_s = 1'b1;
      waddr_s  = rd_r;
      wdata_s  = bus_s;
    end else begin
      wr_req_s = 1'b0;
    end
    we_s = wr_req_s && !((R0_ZERO != 0) && (waddr_s == {AW{1'b0}}));
  end

  // Register file.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else if (we_s) begin
      regs_r[waddr_s] <= wdata_s;
    end
  end

  // Datapath latches, result registers and status flags.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_r   <= 3'd0;
      rs_r   <= {AW{1'b0}};
      rt_r   <= {AW{1'b0}};
      rd_r   <= {AW{1'b0}};
      y_r    <= {DATA_W{1'b0}};
      z_r    <= {(2*DATA_W){1'b0}};
      hi_r   <= {DATA_W{1'b0}};
      lo_r   <= {DATA_W{1'b0}};
      zero_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (latch_s) begin
        op_r <= op;
        rs_r <= rs;
        rt_r <= rt;
        rd_r <= rd;
      end
      if (state_r == TA) y_r <= bus_s;
      if (state_r == TB) z_r <= alu(op_r, y_r, bus_s);
      if (state_r == TW) begin
        if (op_r == OP_MUL) begin
          hi_r   <= z_r[2*DATA_W-1:DATA_W];
          lo_r   <= z_r[DATA_W-1:0];
          zero_r <= (z_r == {(2*DATA_W){1'b0}});
        end else begin
          zero_r <= (z_r[DATA_W-1:0] == {DATA_W{1'b0}});
        end
      end
      done_r <= (state_r == TW);
    end
  end

  assign busy    = (state_r != IDLE);
  assign done    = done_r;
  assign zero    = zero_r;
  assign hi      = hi_r;
  assign lo      = lo_r;
  assign rd_data = mask_r0(rd_addr, regs_r[rd_addr]);

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: a default 32-bit instance and an
// 8-bit, 4-register instance with R0 hardwired to zero.
module tb_bus_datapath_seq;
  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0, ext_we = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [3:0]  rs = 4'd0, rt = 4'd0, rd = 4'd0, ext_addr = 4'd0, rd_addr = 4'd0;
  logic [31:0] ext_wdata = 32'd0, rd_data, hi, lo;
  logic        busy, done, zero;

  logic        s_start = 1'b0, s_ext_we = 1'b0;
  logic [2:0]  s_op = 3'd0;
  logic [1:0]  s_rs = 2'd0, s_rt = 2'd0, s_rd = 2'd0, s_ext_addr = 2'd0, s_rd_addr = 2'd0;
  logic [7:0]  s_ext_wdata = 8'd0, s_rd_data, s_hi, s_lo;
  logic        s_busy, s_done, s_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_datapath_seq dut (
    .clock(clk), .clear(clear), .start(start), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .zero(zero), .hi(hi), .lo(lo)
  );

  bus_datapath_seq #(.DATA_W(8), .NUM_REGS(4), .R0_ZERO(1)) dut8 (
    .clock(clk), .clear(clear), .start(s_start), .op(s_op), .rs(s_rs), .rt(s_rt), .rd(s_rd),
    .ext_we(s_ext_we), .ext_addr(s_ext_addr), .ext_wdata(s_ext_wdata), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .busy(s_busy), .done(s_done), .zero(s_zero), .hi(s_hi), .lo(s_lo)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] v);
    ext_we = 1'b1; ext_addr = a; ext_wdata = v;
    tick();
    ext_we = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [31:0] v);
    rd_addr = a; #1;
    v = rd_data;
  endtask

  // Launch one op and wait (bounded) for done; reports cycles to done and busy samples.
  task automatic do_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, output int cyc, output int bsy);
    op = o; rs = a; rt = b; rd = d; start = 1'b1;
    tick();
    start = 1'b0; ext_we = 1'b0;
    cyc = 0; bsy = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) bsy++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    start = 1'b1; ext_we = 1'b1; ext_addr = 4'd1; ext_wdata = 32'd5;
    repeat (2) tick();
    read_reg(4'd1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_reg: got %h expected 0", v); end
    checks++; if ({busy, done, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, zero}); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    start = 1'b0; ext_we = 1'b0;
    clear = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_add();
    int cyc, bsy; logic [31:0] v;
    preload(4'd1, 32'd5); preload(4'd2, 32'd3);
    do_op(3'd0, 4'd1, 4'd2, 4'd3, cyc, bsy);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL add_latency: got %0d expected 3", cyc); end
    checks++; if (bsy !== 3) begin errors++; $display("FAIL add_busy: got %0d expected 3", bsy); end
    read_reg(4'd3, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL add_result: got %h expected 8", v); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b expected 0", zero); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL add_done_pulse: got %b expected 00", {done, busy}); end
  endtask

  task automatic test_sub();
    int cyc, bsy; logic [31:0] v;
    preload(4'd1, 32'd3); preload(4'd2, 32'd3);
    do_op(3'd1, 4'd1, 4'd2, 4'd4, cyc, bsy);
    read_reg(4'd4, v);
    checks++; if (v !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL sub_zero: got %h/%b expected 0/1", v, zero); end
    preload(4'd1, 32'd0); preload(4'd2, 32'd1);
    do_op(3'd1, 4'd1, 4'd2, 4'd4, cyc, bsy);
    read_reg(4'd4, v);
    checks++; if (v !== 32'hFFFF_FFFF || zero !== 1'b0) begin errors++; $display("FAIL sub_wrap: got %h/%b expected ffffffff/0", v, zero); end
  endtask

  task automatic test_mul();
    int cyc, bsy; logic [31:0] v;
    preload(4'd5, 32'h1234);
    preload(4'd1, 32'h0001_0000); preload(4'd2, 32'h0001_0000);
    do_op(3'd6, 4'd1, 4'd2, 4'd5, cyc, bsy);
    checks++; if (hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("FAIL mul_hilo: got %h_%h expected 00000001_00000000", hi, lo); end
    read_reg(4'd5, v);
    checks++; if (v !== 32'h1234) begin errors++; $display("FAIL mul_rd_kept: got %h expected 1234", v); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL mul_zero: got %b expected 0", zero); end
    preload(4'd1, 32'hFFFF_FFFF); preload(4'd2, 32'hFFFF_FFFF);
    do_op(3'd6, 4'd1, 4'd2, 4'd5, cyc, bsy);
    checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin errors++; $display("FAIL mul_max: got %h_%h expected fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_logic_shift();
    int cyc, bsy; logic [31:0] v;
    preload(4'd1, 32'd1); preload(4'd2, 32'd33);
    do_op(3'd4, 4'd1, 4'd2, 4'd6, cyc, bsy);
    read_reg(4'd6, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL shl_mask: got %h expected 2", v); end
    preload(4'd1, 32'h8000_0000); preload(4'd2, 32'd31);
    do_op(3'd5, 4'd1, 4'd2, 4'd6, cyc, bsy);
    read_reg(4'd6, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL shr_31: got %h expected 1", v); end
    preload(4'd1, 32'h0000_F0F0); preload(4'd2, 32'h0000_FF00);
    do_op(3'd2, 4'd1, 4'd2, 4'd7, cyc, bsy);
    do_op(3'd3, 4'd1, 4'd2, 4'd8, cyc, bsy);
    do_op(3'd7, 4'd1, 4'd2, 4'd9, cyc, bsy);
    read_reg(4'd7, v);
    checks++; if (v !== 32'h0000_F000) begin errors++; $display("FAIL and: got %h expected f000", v); end
    read_reg(4'd8, v);
    checks++; if (v !== 32'h0000_FFF0) begin errors++; $display("FAIL or: got %h expected fff0", v); end
    read_reg(4'd9, v);
    checks++; if (v !== 32'h0000_F0F0) begin errors++; $display("FAIL pass: got %h expected f0f0", v); end
  endtask

  task automatic test_alias_and_simul();
    int cyc, bsy; logic [31:0] v;
    preload(4'd10, 32'd7);
    do_op(3'd0, 4'd10, 4'd10, 4'd10, cyc, bsy);
    read_reg(4'd10, v);
    checks++; if (v !== 32'd14) begin errors++; $display("FAIL alias: got %h expected e", v); end
    preload(4'd11, 32'd3); preload(4'd12, 32'd1);
    ext_we = 1'b1; ext_addr = 4'd11; ext_wdata = 32'd20;
    do_op(3'd0, 4'd11, 4'd12, 4'd13, cyc, bsy);
    read_reg(4'd13, v);
    checks++; if (v !== 32'd21) begin errors++; $display("FAIL start_with_preload: got %h expected 15", v); end
  endtask

  task automatic test_back_to_back_ignore();
    int cyc; logic [31:0] v;
    preload(4'd1, 32'd100); preload(4'd2, 32'd23); preload(4'd15, 32'h77);
    op = 3'd0; rs = 4'd1; rt = 4'd2; rd = 4'd14; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = 3'd1; ext_we = 1'b1; ext_addr = 4'd15; ext_wdata = 32'h99;
    tick();
    start = 1'b0; ext_we = 1'b0;
    cyc = 2;
    while (done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL inflight_latency: got %0d expected 3", cyc); end
    read_reg(4'd14, v);
    checks++; if (v !== 32'd123) begin errors++; $display("FAIL inflight_result: got %h expected 7b", v); end
    read_reg(4'd15, v);
    checks++; if (v !== 32'h77) begin errors++; $display("FAIL inflight_ext_we: got %h expected 77", v); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inflight_start: busy=%b expected 0", busy); end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    preload(4'd1, 32'd4); preload(4'd2, 32'd5);
    op = 3'd0; rs = 4'd1; rt = 4'd2; rd = 4'd14; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_no_done: got %b expected 00", {busy, done}); end
    end
    read_reg(4'd14, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL abort_rd: got %h expected 0", v); end
  endtask

  task automatic s_do_op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d, output int cyc);
    s_op = 3'd0; s_rs = a; s_rt = b; s_rd = d; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    cyc = 0;
    while (s_done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
  endtask

  task automatic test_small_r0();
    int cyc;
    s_ext_we = 1'b1; s_ext_addr = 2'd0; s_ext_wdata = 8'hAA;
    tick();
    s_ext_addr = 2'd1; s_ext_wdata = 8'hFF;
    tick();
    s_ext_we = 1'b0; s_rd_addr = 2'd0; #1;
    checks++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL r0_read: got %h expected 00", s_rd_data); end
    s_do_op(2'd0, 2'd1, 2'd2, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL small_latency: got %0d expected 3", cyc); end
    s_rd_addr = 2'd2; #1;
    checks++; if (s_rd_data !== 8'hFF) begin errors++; $display("FAIL small_r0_add: got %h expected ff", s_rd_data); end
    s_do_op(2'd1, 2'd1, 2'd3, cyc);
    s_rd_addr = 2'd3; #1;
    checks++; if (s_rd_data !== 8'hFE) begin errors++; $display("FAIL small_wrap: got %h expected fe", s_rd_data); end
    s_do_op(2'd1, 2'd1, 2'd0, cyc);
    s_rd_addr = 2'd0; #1;
    checks++; if (s_rd_data !== 8'h00 || s_zero !== 1'b0) begin errors++; $display("FAIL r0_write_drop: got %h/%b expected 00/0", s_rd_data, s_zero); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_logic_shift();
    test_alias_and_simul();
    test_back_to_back_ignore();
    test_abort();
    test_small_r0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
